// File: rtl/iob_mem_arb2_pkg.sv
// Shared constants and helpers for the two-master IOb memory arbiter.
package iob_mem_arb2_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Lone requester wins; on conflict the master not served last wins.
  function automatic logic rr_pick(
    input logic [1:0] req,
    input logic       last
  );
    if (&req) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/iob_mem_arb2_rr.sv
// Two-request round-robin grant with a registered last-grant pointer.
module iob_rr_arb2
  import iob_mem_arb2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

  logic last_grant;

  assign grant = rr_pick(req, last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/iob_mem_arb2.sv
// Round-robin arbiter merging instruction and data IOb masters onto
// one slave port, with a per-transaction response watchdog.
module iob_mem_arb2
  import iob_mem_arb2_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 1023,
  parameter  int TO_W    = 10,
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  m0_req,
  output logic [RESP_W-1:0] m0_resp,
  input  logic [REQ_W-1:0]  m1_req,
  output logic [RESP_W-1:0] m1_resp,
  output logic [REQ_W-1:0]  s_req,
  input  logic [RESP_W-1:0] s_resp,
  output logic              err
);

  localparam int VALID_POS = REQ_W - 1;
  localparam int FIELD_W   = REQ_W - 1;
  localparam logic [DATA_W-1:0] ERR_DATA = '1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TO_EN ? TIMEOUT - 1 : 0);

  logic [1:0]        state;
  logic [TO_W-1:0]   cnt;
  logic              gnt;
  logic              grant;
  logic [1:0]        valid;
  logic              start;
  logic [FIELD_W-1:0] sel_fields;
  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;
  logic              expire;
  logic [DATA_W-1:0] resp_data;

  assign valid = {m1_req[VALID_POS], m0_req[VALID_POS]};
  assign start = (state == ST_IDLE) && (|valid);

  assign sel_fields = grant ? m1_req[FIELD_W-1:0]
                            : m0_req[FIELD_W-1:0];

  assign s_ready   = s_resp[0];
  assign s_rdata   = s_resp[RESP_W-1:1];
  assign expire    = TO_EN && (cnt == TO_LAST) && !s_ready;
  assign resp_data = s_ready ? s_rdata : ERR_DATA;

  iob_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (valid),
    .update (start),
    .grant  (grant)
  );

  // s_req doubles as the capture register for the granted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gnt     <= 1'b0;
      s_req   <= '0;
      m0_resp <= '0;
      m1_resp <= '0;
      err     <= 1'b0;
    end else begin
      m0_resp <= '0;
      m1_resp <= '0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_BUSY;
            gnt   <= grant;
            cnt   <= '0;
            s_req <= {1'b1, sel_fields};
          end
        end
        ST_BUSY: begin
          if (s_ready || expire) begin
            state <= ST_DONE;
            s_req <= '0;
            err   <= !s_ready;
            if (gnt) m1_resp <= {resp_data, 1'b1};
            else     m0_resp <= {resp_data, 1'b1};
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          s_req <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_mem_arb2.sv
// Self-checking bench for iob_mem_arb2 against a transaction-level model.
module tb_iob_mem_arb2;

  localparam int T      = 8;
  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [REQ_W-1:0]  m0_req, m1_req, s_req;
  logic [RESP_W-1:0] m0_resp, m1_resp, s_resp;
  logic              err;

  always #5 clk = ~clk;

  iob_mem_arb2 #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (T),
    .TO_W    (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m0_req  (m0_req),
    .m0_resp (m0_resp),
    .m1_req  (m1_req),
    .m1_resp (m1_resp),
    .s_req   (s_req),
    .s_resp  (s_resp),
    .err     (err)
  );

  bit          mv[2];
  logic [31:0] ma[2];
  logic [31:0] mw[2];
  logic [3:0]  ms[2];
  int          last = 1;
  int          total = 0;
  int          fails = 0;

  task automatic drive();
    m0_req = {mv[0], ma[0], mw[0], ms[0]};
    m1_req = {mv[1], ma[1], mw[1], ms[1]};
  endtask

  task automatic check(input string tag,
                       input logic [159:0] obs,
                       input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] outs();
    return {s_req, m0_resp, m1_resp, err};
  endfunction

  task automatic set_master(input int m, input logic [31:0] a,
                            input logic [31:0] w, input logic [3:0] s);
    mv[m] = 1'b1;
    ma[m] = a;
    mw[m] = w;
    ms[m] = s;
    drive();
  endtask

  // Entered at an IDLE negedge with at least one valid; leaves at IDLE.
  task automatic do_txn(input int delay, input logic [31:0] rd,
                        input bit mutate);
    int          g;
    int          nb;
    bit          to;
    logic [68:0] exp_req;
    logic [31:0] exp_rd;
    logic [32:0] r0, r1;
    if (mv[0] && mv[1]) g = 1 - last;
    else                g = mv[1] ? 1 : 0;
    last    = g;
    exp_req = {1'b1, ma[g], mw[g], ms[g]};
    to      = (delay >= T);
    nb      = to ? T : delay + 1;
    exp_rd  = to ? 32'hFFFF_FFFF : rd;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      check("busy", outs(), {exp_req, 67'b0});
      if (i == 0 && mutate) begin
        ma[g] = $urandom;
        mw[g] = $urandom;
        ms[g] = 4'($urandom);
        drive();
      end
      s_resp = {(i == delay) ? rd : 32'($urandom), i == delay};
    end
    @(negedge clk);
    s_resp = {32'($urandom), to};
    r0 = (g == 0) ? {exp_rd, 1'b1} : 33'b0;
    r1 = (g == 1) ? {exp_rd, 1'b1} : 33'b0;
    check("done", outs(), {69'b0, r0, r1, to});
    mv[g] = 1'b0;
    drive();
    @(negedge clk);
    s_resp = '0;
    check("idle_after", outs(), '0);
  endtask

  task automatic idle_gap(input int n, input bit late);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_gap", outs(), '0);
      s_resp = late ? {32'($urandom), 1'b1} : 33'b0;
    end
    @(negedge clk);
    s_resp = '0;
    check("idle_gap_end", outs(), '0);
  endtask

  initial begin
    mv[0] = 0; mv[1] = 0;
    ma[0] = 0; ma[1] = 0;
    mw[0] = 0; mw[1] = 0;
    ms[0] = 0; ms[1] = 0;
    s_resp = '0;
    drive();
    #2 rst = 1'b1;
    @(negedge clk);
    check("reset", outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", outs(), '0);

    // Single read from m0, slave ready on the third BUSY cycle.
    set_master(0, 32'h100, 32'($urandom), 4'h0);
    do_txn(2, 32'h1234_5678, 0);

    // Reset in the middle of a transaction drops it.
    set_master(0, 32'h200, 32'h1111_1111, 4'hF);
    set_master(1, 32'h300, 32'h2222_2222, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async", outs(), '0);
    @(negedge clk);
    rst  = 1'b0;
    last = 1;
    check("rst_release", outs(), '0);

    // Conflicts after reset: m0, then m1, then m0, then m1 alone.
    do_txn(1, 32'hCAFE_0001, 0);
    do_txn(3, 32'hCAFE_0002, 0);
    set_master(0, 32'h400, 32'h0, 4'h0);
    set_master(1, 32'h500, 32'h0, 4'h0);
    do_txn(0, 32'hCAFE_0003, 0);
    do_txn(0, 32'hCAFE_0004, 0);

    // Write from m1 whose fields change while BUSY.
    set_master(1, 32'h8, 32'hAABB_CCDD, 4'b0011);
    do_txn(1, 32'h0, 1);

    // Silent slave: watchdog fires, late ready afterwards is ignored.
    set_master(0, 32'h600, 32'h0, 4'h0);
    do_txn(20, 32'h0, 0);
    idle_gap(3, 1);

    // Ready lands in the expiry cycle: normal response wins.
    set_master(0, 32'h700, 32'h0, 4'h0);
    do_txn(T - 1, 32'h5A5A_5A5A, 0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!mv[m] && $urandom_range(0, 1) == 1)
          set_master(m, $urandom, $urandom, 4'($urandom));
      end
      if (!mv[0] && !mv[1]) begin
        idle_gap(1, $urandom_range(0, 1) == 1);
        set_master($urandom_range(0, 1), $urandom, $urandom,
                   4'($urandom));
      end
      do_txn($urandom_range(0, 11), $urandom,
             $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/iob_mem_arb2.md
# iob_mem_arb2

Two-master, one-slave arbiter for the IOb native bus. It sits directly downstream of the CPU wrapper and merges the instruction bus (master 0) and data bus (master 1) onto a single memory/interconnect port. Arbitration is round-robin. Each master's request is captured in a register and replayed to the slave, and responses are routed back only to the master that owns the transaction. A per-transaction watchdog terminates transactions that hang.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8, RESP_W = DATA_W+1
- TIMEOUT, 1023, slave-response watchdog in cycles; 0 disables the watchdog
- TO_W, 10, watchdog counter width; requires TIMEOUT < 2**TO_W

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous active-high reset
- m0_req  in  REQ_W  instruction master request {valid, addr, wdata, wstrb}, MSB first
- m0_resp  out  RESP_W  {rdata, ready}, ready at bit 0
- m1_req  in  REQ_W  data master request, same layout
- m1_resp  out  RESP_W  data master response
- s_req  out  REQ_W  slave request
- s_resp  in  RESP_W  slave response
- err  out  1  one-cycle pulse when the watchdog terminates a transaction

## Operation
Bus protocol:
- A master holds valid with stable fields until it sees ready.
- ready is a single-cycle pulse. Every transaction gets one, reads and writes alike.
- wstrb==0 means read. Fields pass through unchanged; no width or strobe conversion.

FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If either valid is set, grant a master and capture its addr/wdata/wstrb. Next state is BUSY.
  - If both are valid, grant the master not granted last. last_grant resets to 1, so m0 wins the first conflict.
  - If neither is valid, stay in IDLE.
- BUSY:
  - s_req = {1, captured fields}. Master-side changes are ignored.
  - When s_resp.ready=1: capture rdata; next state is DONE.
  - When the watchdog expires with no ready that cycle: rdata is set to all-ones, the error flag is set, and next state is DONE.
- DONE:
  - s_req = 0.
  - Granted master's resp = {captured rdata, 1}; other resp = 0.
  - err = error flag.
  - Next state is IDLE. The DONE cycle masks the served master's still-asserted valid.

Other rules:
- The watchdog counter clears on entering BUSY and increments each BUSY cycle without ready. It expires when count == TIMEOUT-1, giving the slave exactly TIMEOUT BUSY cycles. If ready arrives in the expiry cycle, the normal response wins and err=0.
- Any s_resp.ready outside BUSY is discarded (late slave after timeout).
- The non-granted master's resp is always 0.

## Timing
- Reset values: s_req=0, m0_resp=0, m1_resp=0, err=0, state=IDLE, last_grant=1, counter=0.
- Reset mid-transaction: all outputs go to 0 asynchronously and the transaction is dropped with no response.
- All outputs are registered. No combinational path from any input to any output.
- Cycle t: valid seen in IDLE. t+1: s_req valid. Slave ready at cycle k ≥ t+1. k+1: master ready (DONE). k+2: IDLE, arbitrating again.
- Minimum latency is 2 cycles, valid to ready. Peak throughput is one transaction per 3 cycles.

## Structure
- Field offsets and REQ_W/RESP_W come from the shared interconnect header macros (valid/address/wdata/wstrb/rdata/ready). No new shared constants.
- State encodings and the all-ones error pattern are localparams.
- One sub-module, iob_rr_arb2: a 2-request round-robin grant with a registered last_grant, updated only on IDLE→BUSY.

## Test plan
- m0 read addr 0x100, wstrb 0, slave ready 2 cycles after s_req valid with rdata 0x12345678 -> m0_resp ready for 1 cycle with 0x12345678 at k+1. m1_resp stays 0 and err stays 0.
- m0 and m1 both valid from reset -> m0 served first, then m1. Then both valid again -> m0 granted; then m1 alone valid -> m1 granted.
- m1 write addr 0x8, wdata 0xAABBCCDD, wstrb 4'b0011; m1 fields changed while BUSY -> s_req shows the originally captured fields unchanged; m1 gets a single ready.
- TIMEOUT=8, slave silent -> s_req valid for exactly 8 cycles, then granted resp ready with rdata 0xFFFFFFFF and err=1 for one cycle. A slave ready 3 cycles later is ignored.
- TIMEOUT=8, slave ready on the 8th BUSY cycle with 0x5A5A5A5A -> normal response 0x5A5A5A5A, err=0.
- rst asserted mid-BUSY -> s_req, m0_resp, m1_resp and err are 0 in the same cycle. After release with both valid, m0 is granted first.
